// File: rtl/rv64_pkg.sv
// Shared RV64 core definitions: data width, register addressing and
// the write-back payload carried from execute/memory to the register file.
package rv64_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; a push is refused while full even if
// a pop happens on the same edge.
module wb_fifo
    import rv64_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        din,
    output wb_entry_t        dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Arbitrates ALU and queued load results onto the register-file write port and
// tracks registers with outstanding writes for decode's RAW stall logic.
module reg_writeback_ctrl
    import rv64_pkg::*;
#(
    parameter int unsigned XLEN     = rv64_pkg::XLEN,
    parameter int unsigned NUM_REGS = rv64_pkg::NUM_REGS,
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [REG_ADDR_W-1:0] load_rd,
    input  logic [XLEN-1:0]       load_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  regwrite,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [XLEN-1:0]       write_data,
    output logic [NUM_REGS-1:0]   busy_mask
);

    localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

    wb_entry_t             lq_head;
    wb_entry_t             load_entry;
    wb_entry_t             sel_entry;
    logic                  lq_full;
    logic                  lq_empty;
    logic [CNT_W-1:0]      lq_count;
    logic                  lq_pop;
    logic                  sel_valid;
    logic                  regwrite_d;
    logic [REG_ADDR_W-1:0] write_reg_d;
    logic [XLEN-1:0]       write_data_d;
    logic [NUM_REGS-1:0]   busy_d;

    assign load_entry = '{rd: load_rd, data: load_data};

    wb_fifo #(.DEPTH(LQ_DEPTH)) u_load_q (
        .clock (clock),
        .reset (reset),
        .push  (load_valid),
        .pop   (lq_pop),
        .din   (load_entry),
        .dout  (lq_head),
        .full  (lq_full),
        .empty (lq_empty),
        .count (lq_count)
    );

    // Readiness depends only on the queue occupancy, never on the valids.
    assign load_ready = (lq_count != CNT_W'(LQ_DEPTH));
    assign alu_ready  = (lq_count != CNT_W'(LQ_DEPTH));

    // A full queue always drains so the ALU cannot starve loads.
    always_comb begin
        lq_pop    = 1'b0;
        sel_valid = 1'b0;
        sel_entry = lq_head;
        if (lq_full) begin
            lq_pop    = 1'b1;
            sel_valid = 1'b1;
        end else if (alu_valid) begin
            sel_valid = 1'b1;
            sel_entry = '{rd: alu_rd, data: alu_data};
        end else if (!lq_empty) begin
            lq_pop    = 1'b1;
            sel_valid = 1'b1;
        end
    end

    // Next write-port values and scoreboard; a same-edge set beats the clear.
    always_comb begin
        regwrite_d   = sel_valid && (sel_entry.rd != '0);
        write_reg_d  = write_reg;
        write_data_d = write_data;
        if (sel_valid) begin
            write_reg_d  = sel_entry.rd;
            write_data_d = sel_entry.data;
        end
        busy_d = busy_mask;
        if (regwrite)                           busy_d[write_reg] = 1'b0;
        if (issue_valid && (issue_rd != '0))    busy_d[issue_rd]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regwrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            busy_mask  <= '0;
        end else begin
            regwrite   <= regwrite_d;
            write_reg  <= write_reg_d;
            write_data <= write_data_d;
            busy_mask  <= busy_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: directed scenarios plus random
// traffic against a queue-based model of the write-back arbitration.
module tb_reg_writeback_ctrl;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [63:0] alu_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [4:0]  load_rd = '0;
    logic [63:0] load_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [31:0] busy_mask;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ent_t        lq[$];
    exp_t        exp_q[$];
    logic [31:0] busy_m = '0;
    bit          pw_v = 0;
    logic [4:0]  pw_rd = '0;

    reg_writeback_ctrl #(.XLEN(64), .NUM_REGS(32), .LQ_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_rd     (load_rd),
        .load_data   (load_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .regwrite    (regwrite),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .busy_mask   (busy_mask)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every write-port cycle must match the oldest due expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_en", 64'(regwrite), 64'd1);
                chk("wr_reg", 64'(write_reg), 64'(e.rd));
                chk("wr_data", write_data, e.data);
            end else begin
                chk("no_write", 64'(regwrite), 64'd0);
            end
        end
    end

    // One cycle of stimulus plus the reference model's view of that cycle.
    task automatic step(input bit av, input logic [4:0] ard, input logic [63:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [63:0] ld,
                        input bit iv, input logic [4:0] ird);
        bit          full;
        bit          have;
        ent_t        sel;
        logic [31:0] nb;
        @(negedge clock);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        load_valid = lv; load_rd = lrd; load_data = ld;
        issue_valid = iv; issue_rd = ird;
        full = (lq.size() == DEPTH);
        chk("alu_ready", 64'(alu_ready), 64'(!full));
        chk("load_ready", 64'(load_ready), 64'(!full));
        chk("busy_mask", 64'(busy_mask), 64'(busy_m));
        have = 0;
        sel = '{rd: '0, data: '0};
        if (full) begin
            sel = lq.pop_front(); have = 1;
        end else if (av) begin
            sel = '{rd: ard, data: ad}; have = 1;
        end else if (lq.size() > 0) begin
            sel = lq.pop_front(); have = 1;
        end
        if (lv && !full) lq.push_back('{rd: lrd, data: ld});
        nb = busy_m;
        if (pw_v) nb[pw_rd] = 1'b0;
        if (iv && ird != 0) nb[ird] = 1'b1;
        busy_m = nb;
        pw_v = have && (sel.rd != 0);
        pw_rd = sel.rd;
        if (pw_v) exp_q.push_back('{rd: sel.rd, data: sel.data, due: cyc + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_regwrite", 64'(regwrite), 64'd0);
        chk("rst_write_reg", 64'(write_reg), 64'd0);
        chk("rst_write_data", write_data, 64'd0);
        chk("rst_busy", 64'(busy_mask), 64'd0);
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        @(negedge clock);
        reset = 1'b0;

        // First ALU write.
        step(0, 0, 0, 0, 0, 0, 1, 5'd1);
        step(1, 5'd1, 64'd200, 0, 0, 0, 0, 0);
        idle(2);

        // x0 results are consumed but never written or tracked.
        step(0, 0, 0, 0, 0, 0, 1, 5'd0);
        step(1, 5'd0, 64'd100, 0, 0, 0, 0, 0);
        idle(2);

        // ALU and load contend in the same cycle.
        step(0, 0, 0, 0, 0, 0, 1, 5'd2);
        step(0, 0, 0, 0, 0, 0, 1, 5'd3);
        step(1, 5'd2, 64'd300, 1, 5'd3, 64'd400, 0, 0);
        idle(3);

        // Fill the load queue while the ALU keeps winning, then drain.
        for (int i = 0; i < 6; i++)
            step(1, 5'(10 + i), 64'(1000 + i), 1, 5'(20 + i), 64'(2000 + i), 0, 0);
        idle(6);

        // Same-edge set and clear of reg 5: the set wins.
        step(0, 0, 0, 0, 0, 0, 1, 5'd5);
        step(1, 5'd5, 64'd555, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd5);
        idle(1);
        chk("busy5_kept", 64'(busy_mask[5]), 64'd1);
        step(1, 5'd5, 64'd556, 0, 0, 0, 0, 0);
        idle(3);

        // Async reset while three loads are still queued.
        for (int i = 0; i < 3; i++)
            step(1, 5'(6 + i), 64'(3000 + i), 1, 5'(12 + i), 64'(4000 + i), 1, 5'(12 + i));
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        lq.delete(); exp_q.delete(); busy_m = '0; pw_v = 0;
        #1;
        chk("arst_regwrite", 64'(regwrite), 64'd0);
        chk("arst_write_reg", 64'(write_reg), 64'd0);
        chk("arst_write_data", write_data, 64'd0);
        chk("arst_busy", 64'(busy_mask), 64'd0);
        chk("arst_load_ready", 64'(load_ready), 64'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle(4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int mode;
            mode = (i / 100) % 2;
            step($urandom_range(0, 99) < (mode ? 85 : 40), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom},
                 $urandom_range(0, 99) < (mode ? 70 : 45), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom},
                 $urandom_range(0, 99) < 50, 5'($urandom_range(0, 31)));
        end
        idle(10);
        chk("all_writes_seen", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_writeback_ctrl.md
# reg_writeback_ctrl

Write-side initiator for the 64-bit RISC-V register file: it collects completed results from the ALU and the load unit, arbitrates them onto the register file's single write port (`regwrite`, `write_reg`, `write_data`) at one write per cycle, and keeps a per-register pending scoreboard that decode uses for RAW hazard stalls. It sits between execute/memory and the register file.

## Interface
Parameters:
- `XLEN`, 64, data width of results and write port
- `NUM_REGS`, 32, architectural registers (5-bit index)
- `LQ_DEPTH`, 4, load-result queue depth (power of two, ≥2)

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `alu_valid` in 1: ALU result available
- `alu_ready` out 1: ALU result accepted this cycle when `alu_valid && alu_ready`
- `alu_rd` in 5: ALU destination register
- `alu_data` in XLEN: ALU result
- `load_valid` in 1: load result available
- `load_ready` out 1: load result accepted this cycle when `load_valid && load_ready`
- `load_rd` in 5: load destination register
- `load_data` in XLEN: load result
- `issue_valid` in 1: an instruction with a destination register issues this cycle
- `issue_rd` in 5: its destination register
- `regwrite` out 1: write enable to the register file
- `write_reg` out 5: write address
- `write_data` out XLEN: write data
- `busy_mask` out NUM_REGS: bit i set = register i has an outstanding write

## Operation
- Load queue: FIFO of {rd, data}, `LQ_DEPTH` entries; `load_ready = (count != LQ_DEPTH)`. No push when full, even if a pop happens in the same cycle.
- Arbitration each cycle, in priority order:
  - queue full → pop queue head; `alu_ready = 0`.
  - else `alu_valid` → take ALU; `alu_ready = 1`; queue does not pop.
  - else queue non-empty → pop head.
  - else no write.
- `alu_ready = 1` whenever the queue is not full, independent of `alu_valid`.
- The selected result is registered into `write_reg`/`write_data`; `regwrite` is registered high only if rd ≠ 0. A rd = 0 result is consumed (popped/accepted) but produces `regwrite = 0`.
- Scoreboard: on the edge where `regwrite` is high, clear `busy_mask[write_reg]`. On the edge where `issue_valid` is high and `issue_rd` ≠ 0, set `busy_mask[issue_rd]`. If both target the same register on the same edge, the set wins (the newer producer is outstanding). Bit 0 is always 0.
- Push and pop on the same edge: count is unchanged, and the pointers wrap modulo `LQ_DEPTH`.

## Timing
- Reset (async assert): `regwrite=0`, `write_reg=0`, `write_data=0`, `busy_mask=0`, queue empty (count=0, pointers=0), so `load_ready=1` and `alu_ready=1`. Queue contents are discarded if reset asserts mid-operation.
- ALU latency: accepted in cycle N → `regwrite` is high in cycle N+1, and the register file commits at the end of N+1. The busy bit is low from cycle N+2.
- Load latency: minimum 2 (push at end of N, pop in N+1, `regwrite` high in N+2). This increases by one cycle for each intervening ALU win.
- Throughput is one write per cycle. A full queue drains at least one entry per cycle, so the ALU cannot starve loads indefinitely.
- `alu_ready` and `load_ready` are combinational from registered state only (count); they have no path from the valid inputs.

## Structure
- Shared package `rv64_pkg`: `XLEN`, `REG_ADDR_W = 5`, `NUM_REGS`, and struct `wb_entry_t` {rd[4:0], data[XLEN-1:0]}. The register file already uses, or should use, the same package.
- One sub-module: `wb_fifo`, a parameterised sync FIFO with the same async active-high reset, ports push/pop/full/empty/count, and data of type `wb_entry_t`.
- Top level holds the arbiter, output registers and scoreboard.

## Test plan
- Reset: hold `reset=1` → all outputs 0, `load_ready=1`, `alu_ready=1`. Deassert, then ALU {rd=1, 200} → `regwrite=1`, `write_reg=1`, `write_data=200` one cycle later.
- x0 suppression: `issue_rd=0`, then ALU {rd=0, 100} → `regwrite` stays 0, `busy_mask[0]=0`, `alu_ready=1`.
- Contention: ALU {2, 300} and load {3, 400} in the same cycle → write reg 2 in N+1 and reg 3 in N+2; `busy_mask` bits 2 and 3 set at issue and cleared after their respective writes.
- Full queue: hold `alu_valid=1` and push 4 loads → `load_ready=0` and `alu_ready=0`. Queued loads then drain in FIFO order, one per cycle. `alu_ready` returns to 1 once the count is 3.
- Set/clear collision: `issue_valid` with `issue_rd=5` on the same edge that writes reg 5 → `busy_mask[5]` remains 1.
- Async reset mid-drain with 3 entries queued → outputs go to 0 immediately without a clock edge. After release, no stale writes appear.
